ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV32I pipeline, directly downstream of ID. Holds the ID/EX pipeline

---
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_stage.sv | 97 +++++++++
 tb/tb_ex_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX boundary bundle: decoded instruction fields in, EX results and hazard-visible fields out.
interface ex_stage_if;
  logic        FlushE;
  logic [31:0] RD1D, RD2D, PCD, PCplus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;

  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCplus4E;
  logic        PCSrcE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [1:0]  ResultSrcE;
  logic        RegWriteE, MemWriteE;

  modport master (
    output FlushE, RD1D, RD2D, PCD, PCplus4D, ImmExtD, Rs1D, Rs2D, RdD,
           ResultSrcD, ALUControlD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ForwardAE, ForwardBE, ResultW, ALUResultM,
    input  ALUResultE, WriteDataE, PCTargetE, PCplus4E, PCSrcE, RdE, Rs1E, Rs2E,
           ResultSrcE, RegWriteE, MemWriteE
  );

  modport slave (
    input  FlushE, RD1D, RD2D, PCD, PCplus4D, ImmExtD, Rs1D, Rs2D, RdD,
           ResultSrcD, ALUControlD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ForwardAE, ForwardBE, ResultW, ALUResultM,
    output ALUResultE, WriteDataE, PCTargetE, PCplus4E, PCSrcE, RdE, Rs1E, Rs2E,
           ResultSrcE, RegWriteE, MemWriteE
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: flushable ID/EX register, operand forwarding, ALU and branch/jump resolution.
module ex_stage #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  ex_stage_if.slave   bus
);

  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_control_e;
  logic            reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;

  logic [XLEN-1:0] src_a, src_b, write_data, alu_result;
  logic            zero;

  // Reset and flush both load an all-zero bubble; a bubble decodes as a harmless add with no side effects.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      pc_plus4_e    <= '0;
      imm_ext_e     <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
      result_src_e  <= '0;
      alu_control_e <= '0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
      alu_src_e     <= 1'b0;
    end else begin
      rd1_e         <= bus.RD1D;
      rd2_e         <= bus.RD2D;
      pc_e          <= bus.PCD;
      pc_plus4_e    <= bus.PCplus4D;
      imm_ext_e     <= bus.ImmExtD;
      rs1_e         <= bus.Rs1D;
      rs2_e         <= bus.Rs2D;
      rd_e          <= bus.RdD;
      result_src_e  <= bus.ResultSrcD;
      alu_control_e <= bus.ALUControlD;
      reg_write_e   <= bus.RegWriteD;
      mem_write_e   <= bus.MemWriteD;
      branch_e      <= bus.BranchD;
      jump_e        <= bus.JumpD;
      alu_src_e     <= bus.ALUSrcD;
    end
  end

  // Select code 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUResultM;
      default: src_a = rd1_e;
    endcase
    case (bus.ForwardBE)
      2'b01:   write_data = bus.ResultW;
      2'b10:   write_data = bus.ALUResultM;
      default: write_data = rd2_e;
    endcase
    src_b = alu_src_e ? imm_ext_e : write_data;
  end

  always_comb begin
    case (alu_control_e)
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign zero = (alu_result == '0);

  assign bus.ALUResultE = alu_result;
  assign bus.WriteDataE = write_data;
  assign bus.PCTargetE  = pc_e + imm_ext_e;
  assign bus.PCSrcE     = (branch_e & zero) | jump_e;
  assign bus.PCplus4E   = pc_plus4_e;
  assign bus.RdE        = rd_e;
  assign bus.Rs1E       = rs1_e;
  assign bus.Rs2E       = rs2_e;
  assign bus.ResultSrcE = result_src_e;
  assign bus.RegWriteE  = reg_write_e;
  assign bus.MemWriteE  = mem_write_e;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX outputs built from an independent model.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] target;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val);
    if (sel == 2'b01) return bus.ResultW;
    if (sel == 2'b10) return bus.ALUResultM;
    return reg_val;
  endfunction

  // Expected EX outputs one edge after the current ID inputs, using the forward inputs held at sample time.
  function automatic exp_t model(input bit bubble);
    exp_t        e;
    logic [31:0] rd1, rd2, pc, imm, a, b, w, r;
    logic [2:0]  op;
    logic        asel, br, jmp;
    e = '0;
    rd1 = '0; rd2 = '0; pc = '0; imm = '0; op = 3'b000; asel = 1'b0; br = 1'b0; jmp = 1'b0;
    if (!bubble) begin
      rd1 = bus.RD1D; rd2 = bus.RD2D; pc = bus.PCD; imm = bus.ImmExtD;
      op = bus.ALUControlD; asel = bus.ALUSrcD; br = bus.BranchD; jmp = bus.JumpD;
      e.pcplus4 = bus.PCplus4D; e.regwrite = bus.RegWriteD; e.memwrite = bus.MemWriteD;
      e.resultsrc = bus.ResultSrcD; e.rd = bus.RdD; e.rs1 = bus.Rs1D; e.rs2 = bus.Rs2D;
    end
    a = fwd(bus.ForwardAE, rd1);
    w = fwd(bus.ForwardBE, rd2);
    b = asel ? imm : w;
    case (op)
      3'b001: r = a - b;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      3'b110: r = (a < b) ? 32'd1 : 32'd0;
      default: r = a + b;
    endcase
    e.alu    = r;
    e.wdata  = w;
    e.target = pc + imm;
    e.pcsrc  = (br && (r == 32'd0)) || jmp;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t o;
    o.alu = bus.ALUResultE; o.wdata = bus.WriteDataE; o.target = bus.PCTargetE;
    o.pcplus4 = bus.PCplus4E; o.pcsrc = bus.PCSrcE; o.regwrite = bus.RegWriteE;
    o.memwrite = bus.MemWriteE; o.resultsrc = bus.ResultSrcE; o.rd = bus.RdE;
    o.rs1 = bus.Rs1E; o.rs2 = bus.Rs2E;
    return o;
  endfunction

  task automatic clear_d();
    bus.FlushE = 0; bus.RD1D = 0; bus.RD2D = 0; bus.PCD = 0; bus.PCplus4D = 0; bus.ImmExtD = 0;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0; bus.ResultSrcD = 0; bus.ALUControlD = 0;
    bus.RegWriteD = 0; bus.MemWriteD = 0; bus.BranchD = 0; bus.JumpD = 0; bus.ALUSrcD = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0; bus.ALUResultM = 0;
  endtask

  task automatic rand_d();
    bus.RD1D = $urandom; bus.RD2D = $urandom; bus.PCD = $urandom; bus.PCplus4D = $urandom;
    bus.ImmExtD = $urandom; bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom); bus.RdD = 5'($urandom);
    bus.ResultSrcD = 2'($urandom); bus.ALUControlD = 3'($urandom);
    bus.RegWriteD = 1'($urandom); bus.MemWriteD = 1'($urandom); bus.BranchD = 1'($urandom);
    bus.JumpD = 1'($urandom); bus.ALUSrcD = 1'($urandom);
    bus.ResultW = $urandom; bus.ALUResultM = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got, e;
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1;
      rand_d();
      bus.ForwardAE = 0; bus.ForwardBE = 0;
      sb.push_back(model(1'b1));
      tick();
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %p expected %p", i, got, e);
      end
    end
    reset = 1'b0;
    clear_d();
  endtask

  task automatic test_add();
    exp_t got, e;
    clear_d();
    bus.RD1D = 5; bus.RD2D = 7; bus.ALUControlD = 3'b000; bus.RdD = 5'd3; bus.RegWriteD = 1;
    sb.push_back(model(1'b0));
    e = sb[$];
    if (e.alu !== 32'd12) $display("note: model add disagrees");
    tick();
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got.alu !== 32'd12 || got !== e) begin
      n_fail++;
      $display("FAIL add: got %p expected %p", got, e);
    end
  endtask

  task automatic test_forward();
    exp_t got, e;
    logic [31:0] want [2] = '{32'h104, 32'h24};
    for (int i = 0; i < 2; i++) begin
      clear_d();
      bus.RD1D = 1; bus.ALUControlD = 3'b000; bus.ALUSrcD = 1; bus.ImmExtD = 4;
      bus.ALUResultM = 32'h100; bus.ResultW = 32'h20;
      bus.ForwardAE = (i == 0) ? 2'b10 : 2'b01;
      sb.push_back(model(1'b0));
      tick();
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got.alu !== want[i] || got !== e) begin
        n_fail++;
        $display("FAIL forward[%0d]: got alu %h expected %h (full %p)", i, got.alu, want[i], e);
      end
    end
  endtask

  task automatic test_branch();
    exp_t got, e;
    for (int i = 0; i < 2; i++) begin
      clear_d();
      bus.BranchD = 1; bus.RD1D = 9; bus.RD2D = (i == 0) ? 32'd9 : 32'd8;
      bus.ALUControlD = 3'b001; bus.PCD = 32'h40; bus.ImmExtD = 32'hFFFF_FFF0;
      sb.push_back(model(1'b0));
      tick();
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got.pcsrc !== (i == 0) || got.target !== 32'h30 || got !== e) begin
        n_fail++;
        $display("FAIL beq[%0d]: got pcsrc %b target %h expected pcsrc %b target 30", i, got.pcsrc, got.target, (i == 0));
      end
    end
  endtask

  task automatic test_flush();
    exp_t got, e;
    clear_d();
    rand_d();
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    bus.JumpD = 1; bus.RegWriteD = 1; bus.MemWriteD = 1; bus.RdD = 5'd17; bus.FlushE = 1;
    sb.push_back(model(1'b1));
    tick();
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got.pcsrc !== 1'b0 || got.regwrite !== 1'b0 || got.rd !== 5'd0 || got !== e) begin
      n_fail++;
      $display("FAIL flush: got %p expected %p", got, e);
    end
    bus.FlushE = 0;
  endtask

  task automatic test_slt();
    exp_t got, e;
    for (int i = 0; i < 2; i++) begin
      clear_d();
      bus.RD1D = 32'hFFFF_FFFF; bus.RD2D = 1;
      bus.ALUControlD = (i == 0) ? 3'b101 : 3'b110;
      sb.push_back(model(1'b0));
      tick();
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got.alu !== ((i == 0) ? 32'd1 : 32'd0) || got !== e) begin
        n_fail++;
        $display("FAIL slt[%0d]: got alu %h expected %h", i, got.alu, e.alu);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t got, e;
    clear_d();
    bus.JumpD = 1; bus.PCD = 32'h100; bus.ImmExtD = 32'h20; bus.RegWriteD = 1; bus.RdD = 5'd1;
    sb.push_back(model(1'b0));
    tick();
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got.pcsrc !== 1'b1 || got !== e) begin
      n_fail++;
      $display("FAIL jump_before_reset: got %p expected %p", got, e);
    end
    reset = 1'b1;
    sb.push_back(model(1'b1));
    tick();
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got.pcsrc !== 1'b0 || got !== e) begin
      n_fail++;
      $display("FAIL reset_midstream: got %p expected %p", got, e);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    bit   bubble;
    for (int i = 0; i < 40; i++) begin
      rand_d();
      if ($urandom_range(0, 1) == 1) bus.RD2D = bus.RD1D;
      bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      bubble = ($urandom_range(0, 4) == 0);
      bus.FlushE = bubble;
      sb.push_back(model(bubble));
      tick();
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %p expected %p", i, got, e);
      end
    end
    bus.FlushE = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_d();
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_flush();
    test_slt();
    test_reset_midstream();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
